// File: rtl/restoring_divider.sv
// -----------------------------------------------------------------------------
// restoring_divider
//
// Sequential unsigned integer divider using the restoring algorithm. One
// quotient bit is produced per clock: the partial remainder is shifted left,
// a trial subtraction (P + ~B + 1) is performed, and the shifted value is
// kept (restored) whenever the subtraction borrows.
//
// Handshake: START is sampled only while idle. A non-zero divisor starts a
// WIDTH-cycle run; a zero divisor completes on the very next edge with DIVZ
// set, Q all ones and R equal to the dividend. DONE is a one-cycle pulse in
// the cycle where Q/R/DIVZ take their new values; those outputs then hold
// until the next completion.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module restoring_divider #(
  parameter int WIDTH = 4  // operand width, legal range 2..16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             DIVZ
);

  // Counter must hold the value WIDTH itself, hence WIDTH+1 in the log.
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int PW    = WIDTH + 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_e             state_q, state_d;
  logic [PW-1:0]      p_q,     p_d;     // partial remainder
  logic [WIDTH-1:0]   dvd_q,   dvd_d;   // working dividend, becomes quotient
  logic [WIDTH-1:0]   dvs_q,   dvs_d;   // captured divisor
  logic [CNT_W-1:0]   cnt_q,   cnt_d;   // iterations remaining
  logic [WIDTH-1:0]   q_q,     q_d;     // published quotient
  logic [WIDTH-1:0]   r_q,     r_d;     // published remainder
  logic               divz_q,  divz_d;  // published divide-by-zero flag
  logic               done_q,  done_d;  // completion pulse

  // ---------------------------------------------------------------------------
  // One iteration of the restoring step
  // ---------------------------------------------------------------------------
  logic [PW-1:0]      p_shift;   // P' = {P[W-1:0], dividend MSB}
  logic [PW-1:0]      trial;     // P' - B via two's-complement addition
  logic               no_borrow; // trial subtraction succeeded
  logic [PW-1:0]      p_next;    // remainder after this iteration
  logic [WIDTH-1:0]   dvd_next;  // dividend shifted, quotient bit in LSB

  assign p_shift   = {p_q[WIDTH-1:0], dvd_q[WIDTH-1]};
  assign trial     = p_shift + ~{1'b0, dvs_q} + PW'(1);
  assign no_borrow = ~trial[WIDTH];
  assign p_next    = no_borrow ? trial : p_shift;
  assign dvd_next  = {dvd_q[WIDTH-2:0], no_borrow};

  // Because P stays below the divisor after every iteration, its top bit is
  // always zero between iterations; only the shifted value P' can use it.
  logic unused_p_msb;
  assign unused_p_msb = p_q[WIDTH];

  // ---------------------------------------------------------------------------
  // Next-state and datapath control
  // ---------------------------------------------------------------------------
  // Decide the next state, load operands on acceptance, iterate while running.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; an unassigned path would infer a latch.
    state_d = state_q;
    p_d     = p_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    divz_d  = divz_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          if (B == '0) begin
            // Divide by zero resolves immediately without entering RUN.
            done_d = 1'b1;
            divz_d = 1'b1;
            q_d    = '1;
            r_d    = A;
          end else begin
            dvd_d   = A;
            dvs_d   = B;
            p_d     = '0;
            cnt_d   = CNT_W'(WIDTH);
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        p_d   = p_next;
        dvd_d = dvd_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          // Last iteration: publish results in the same edge.
          state_d = S_IDLE;
          done_d  = 1'b1;
          q_d     = dvd_next;
          r_d     = p_next[WIDTH-1:0];
          divz_d  = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // Update all state on the rising clock; asynchronous reset aborts any run.
  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: every register, datapath included, is reset so no X can ever
    // reach the outputs, and an aborted run leaves nothing behind.
    if (RST) begin
      state_q <= S_IDLE;
      p_q     <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      divz_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      p_q     <= p_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      divz_q  <= divz_d;
      done_q  <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign BUSY = (state_q == S_RUN);
  assign DONE = done_q;
  assign Q    = q_q;
  assign R    = r_q;
  assign DIVZ = divz_q;

endmodule

// File: tb/tb_restoring_divider.sv
// -----------------------------------------------------------------------------
// tb_restoring_divider
//
// Directed bench for restoring_divider at WIDTH=4. Inputs change and outputs
// are sampled on the falling clock edge, half a period away from the active
// edge. Expected values are hand-computed constants, except in the final
// sweep where they come from the integer / and % operators.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_restoring_divider;

  localparam int W = 4;

  logic         CLK;
  logic         RST;
  logic         START;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         BUSY;
  logic         DONE;
  logic [W-1:0] Q;
  logic [W-1:0] R;
  logic         DIVZ;

  int errors = 0;
  int checks = 0;

  restoring_divider #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .A     (A),
    .B     (B),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .Q     (Q),
    .R     (R),
    .DIVZ  (DIVZ)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Single comparison point: counts the check and reports any difference.
  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Start one operation from a falling edge and wait for DONE. On return we
  // sit at the falling edge of the DONE cycle. lat counts falling edges after
  // the accepting edge; busy counts those edges that saw BUSY high.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat, output int busy);
    START = 1'b1;
    A     = a;
    B     = b;
    @(negedge CLK);
    START = 1'b0;
    lat   = 0;
    busy  = 0;
    while (!DONE && lat < 20) begin
      if (BUSY) busy++;
      @(negedge CLK);
      lat++;
    end
    check("done_seen", DONE, 1);
  endtask

  int lat;
  int busy;
  int pulses;
  logic [W-1:0] q_cap;
  logic [W-1:0] r_cap;

  initial begin
    RST   = 1'b1;
    START = 1'b0;
    A     = '0;
    B     = '0;

    // Reset state, observed before any clock edge.
    #1;
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_q",    Q,    0);
    check("rst_r",    R,    0);
    check("rst_divz", DIVZ, 0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    // 13 / 3 = 4 r 1, four busy cycles, DONE four cycles after acceptance.
    do_op(4'd13, 4'd3, lat, busy);
    check("13_3_lat",  lat,  4);
    check("13_3_busy", busy, 4);
    check("13_3_q",    Q,    4);
    check("13_3_r",    R,    1);
    check("13_3_divz", DIVZ, 0);
    @(negedge CLK);
    check("13_3_done_pulse", DONE, 0);
    check("13_3_q_hold",     Q,    4);

    // Reset pulse while idle clears outputs without a clock edge.
    #2 RST = 1'b1;
    #1;
    check("midrst_busy", BUSY, 0);
    check("midrst_done", DONE, 0);
    check("midrst_q",    Q,    0);
    check("midrst_r",    R,    0);
    check("midrst_divz", DIVZ, 0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    // 15 / 1 = 15 r 0 and 7 / 9 = 0 r 7.
    do_op(4'd15, 4'd1, lat, busy);
    check("15_1_q", Q, 15);
    check("15_1_r", R, 0);
    do_op(4'd7, 4'd9, lat, busy);
    check("7_9_q", Q, 0);
    check("7_9_r", R, 7);
    @(negedge CLK);

    // 10 / 0: immediate DONE, DIVZ set, Q all ones, R = dividend, no BUSY.
    do_op(4'd10, 4'd0, lat, busy);
    check("div0_lat",  lat,  0);
    check("div0_busy", BUSY, 0);
    check("div0_divz", DIVZ, 1);
    check("div0_q",    Q,    15);
    check("div0_r",    R,    10);
    @(negedge CLK);
    check("div0_done_pulse", DONE, 0);
    check("div0_divz_hold",  DIVZ, 1);

    // 12 / 5 with a START and new operands pushed during RUN (ignored).
    START = 1'b1;
    A     = 4'd12;
    B     = 4'd5;
    @(negedge CLK);
    A     = 4'd3;
    B     = 4'd1;
    @(negedge CLK);
    START = 1'b0;
    A     = '0;
    B     = '0;
    pulses = 0;
    q_cap  = '0;
    r_cap  = '0;
    for (int i = 0; i < 10; i++) begin
      if (DONE) begin
        pulses++;
        q_cap = Q;
        r_cap = R;
      end
      @(negedge CLK);
    end
    check("ign_pulses", pulses, 1);
    check("ign_q",      q_cap,  2);
    check("ign_r",      r_cap,  2);

    // 9 / 2 aborted by reset in the second RUN cycle: no DONE, outputs clear.
    START = 1'b1;
    A     = 4'd9;
    B     = 4'd2;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    check("abort_busy_before", BUSY, 1);
    #2 RST = 1'b1;
    #1;
    check("abort_busy", BUSY, 0);
    check("abort_q",    Q,    0);
    check("abort_r",    R,    0);
    @(negedge CLK);
    RST = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (DONE) pulses++;
    end
    check("abort_pulses", pulses, 0);
    check("abort_q_end",  Q,      0);
    check("abort_r_end",  R,      0);
    check("abort_busy_end", BUSY, 0);

    // Back-to-back: 14 / 4 then 11 / 3 accepted in the DONE cycle.
    START = 1'b1;
    A     = 4'd14;
    B     = 4'd4;
    @(negedge CLK);
    START = 1'b0;
    repeat (3) @(negedge CLK);
    START = 1'b1;
    A     = 4'd11;
    B     = 4'd3;
    @(negedge CLK);
    check("b2b_done1", DONE, 1);
    check("b2b_q1",    Q,    3);
    check("b2b_r1",    R,    2);
    @(negedge CLK);
    START = 1'b0;
    check("b2b_done_fall", DONE, 0);
    check("b2b_busy_rise", BUSY, 1);
    lat = 0;
    while (!DONE && lat < 20) begin
      @(negedge CLK);
      lat++;
    end
    check("b2b_done2", DONE, 1);
    check("b2b_lat2",  lat,  4);
    check("b2b_q2",    Q,    3);
    check("b2b_r2",    R,    2);
    check("b2b_divz2", DIVZ, 0);
    @(negedge CLK);

    // Exhaustive sweep of all 4-bit operand pairs.
    for (int b = 0; b < 16; b++) begin
      for (int a = 0; a < 16; a++) begin
        do_op(W'(a), W'(b), lat, busy);
        if (b == 0) begin
          check("sweep_z_divz", DIVZ, 1);
          check("sweep_z_q",    Q,    15);
          check("sweep_z_r",    R,    32'(a));
        end else begin
          check("sweep_inv",  32'(int'(Q) * b + int'(R)), 32'(a));
          check("sweep_rlt",  32'(int'(R) < b), 1);
          check("sweep_q",    Q,    32'(a / b));
          check("sweep_lat",  lat,  4);
          check("sweep_divz", DIVZ, 0);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/restoring_divider.md
Name: restoring_divider

Overview:
- Sequential unsigned integer divider; the multi-cycle inverse of the ripple-carry/carry-select adder family.
- Each iteration performs a trial subtraction of the divisor from the partial remainder, using two's-complement addition (P + ~B + 1), and restores the remainder when the subtraction borrows.
- Sits next to the adder blocks in the arithmetic unit.
- Start/done handshake; one quotient bit per clock.

Parameters:
WIDTH, 4, operand width in bits for dividend, divisor, quotient and remainder (legal range 2..16).

Ports:
CLK  input  1  system clock; all state changes on rising edge.
RST  input  1  reset, asynchronous, active-high.
START  input  1  request; sampled only when the block is idle.
A  input  WIDTH  dividend, unsigned; captured on the accepting edge.
B  input  WIDTH  divisor, unsigned; captured on the accepting edge.
BUSY  output  1  high while a division is in progress.
DONE  output  1  one-cycle pulse; Q, R and DIVZ updated in that same cycle.
Q  output  WIDTH  quotient of the last completed operation.
R  output  WIDTH  remainder of the last completed operation.
DIVZ  output  1  divide-by-zero flag of the last completed operation.

Behaviour:
- Reset (RST=1, async, any time including mid-operation):
  - State goes to IDLE.
  - BUSY=0, DONE=0, Q=0, R=0, DIVZ=0.
  - Internal partial remainder, working dividend and iteration counter are all cleared.
  - An aborted operation produces no DONE.
- States: IDLE, RUN.
- IDLE:
  - START=1 at edge k with B!=0: capture A into the working dividend and B into the divisor register. Clear the (WIDTH+1)-bit partial remainder P. Load counter=WIDTH. Go to RUN; BUSY=1 after edge k.
  - START=1 at edge k with B==0: stay in IDLE, BUSY stays 0. After edge k: DONE=1 for one cycle, DIVZ=1, Q=all ones, R=A.
  - START=0: hold all outputs; DONE=0.
- RUN, one iteration per edge:
  - P' = {P[WIDTH-1:0], dividend MSB}; shift the dividend left by one.
  - T = P' + ~{0,B} + 1, computed (WIDTH+1) bits wide.
  - If T[WIDTH]==0 (no borrow): P=T, quotient bit=1. Otherwise P=P' (restore), quotient bit=0.
  - The quotient bit shifts into the working dividend LSB; the register doubles as the quotient.
  - Decrement the counter.
- Completion:
  - At the edge where the counter goes 1->0, i.e. edge k+WIDTH:
    - state goes to IDLE, BUSY=0
    - DONE=1 for exactly one cycle
    - Q = working register, R = P[WIDTH-1:0], DIVZ=0
  - Latency: DONE is high in the cycle after edge k+WIDTH (WIDTH cycles after acceptance); 4 cycles for the default WIDTH.
- Q/R/DIVZ hold their value from completion until the next completion. They do not change during RUN.
- START while BUSY=1: ignored; A/B changes during RUN have no effect.
- START in the DONE cycle: the state is IDLE, so the new operation is accepted. DONE falls on the next edge and BUSY rises on that edge, giving back-to-back operation with no dead cycle.
- Arithmetic invariants on every completed non-zero-divisor operation: A == Q*B + R and R < B.
- No X propagation: every register has a defined reset value.

Test Plan:
- RST pulse mid-idle -> BUSY=0, DONE=0, Q=0, R=0, DIVZ=0 immediately, without waiting for a clock edge.
- A=13, B=3, START for one cycle -> BUSY high for 4 cycles; DONE pulse then Q=4, R=1, DIVZ=0. Also check A=15, B=1 -> Q=15, R=0, and A=7, B=9 -> Q=0, R=7.
- A=10, B=0, START -> DONE in the next cycle with DIVZ=1, Q=15, R=10; BUSY never asserts.
- A=12, B=5 started; during RUN, drive START=1 with A=3, B=1 -> ignored. Result Q=2, R=2; exactly one DONE pulse.
- A=9, B=2 started; assert RST at the 2nd RUN cycle; release and idle for 6 cycles -> no DONE; Q=0, R=0.
- Back-to-back: START held high across the DONE cycle of 14/4 with the next operands 11/3 -> first DONE gives Q=3, R=2; second DONE gives Q=3, R=2 for 11/3, exactly WIDTH cycles later. Exhaustive 4-bit sweep of all A, B checked against A == Q*B + R.
